sha256_ctrl: RTL and testbench
==============================

Name: sha256_ctrl

Overview:
- Sequencer between the 128-bit host write stream and the 512-bit SHA-256 compression core.
- Gathers four 128-bit beats into one block and issues it to the core as init (first block of a message) or next (chained block).
- Waits for core completion, then publishes the final digest once the last block of the message is done.
- Messages arrive pre-padded, so every message is a whole number of 512-bit blocks.

Parameters:
- CNT_W, 16, width of the per-message block counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  128  message beat; first beat of a block lands in block bits [511:384].
- in_valid  in  1  in_data valid.
- in_last  in  1  beat is the last beat of the message; legal only on beat 3 of a block.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- core_block  out  512  block to the core; stable from ISSUE until core_done.
- core_init  out  1  one-cycle start pulse, first block (core loads the IV).
- core_next  out  1  one-cycle start pulse, chained block.
- core_ready  in  1  core idle and able to take a start pulse.
- core_done  in  1  one-cycle pulse: block compression finished.
- core_digest  in  256  core chaining value, valid when core_done=1.
- digest_out  out  256  final message digest.
- digest_valid  out  1  digest_out holds the digest of the most recent message.
- block_cnt  out  CNT_W  blocks completed in the current or most recent message; saturates at all-ones.
- err  out  1  sticky protocol error: in_last seen on beat 0..2.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=FILL, beat_cnt=0, first_blk=1, buffer=0, digest_out=0, block_cnt=0.
  - digest_valid=0, err=0, core_init=0, core_next=0.
  - in_ready=1 once reset is released.
- FILL state:
  - in_ready=1.
  - On accept: buffer <= {buffer[383:0], in_data}; beat_cnt increments, wrapping 3->0.
  - If the first beat of a message (first_blk=1 and beat_cnt=0) is accepted, then digest_valid<=0 and block_cnt<=0.
  - Accept at beat_cnt=3: last_blk<=in_last; go to ISSUE.
  - in_last accepted at beat_cnt<3: err<=1; the partial block is discarded; beat_cnt<=0, first_blk<=1; stay in FILL; the core is not started.
- ISSUE state:
  - in_ready=0.
  - core_init = core_ready && first_blk; core_next = core_ready && !first_blk. Both are decoded from state.
  - When core_ready=1, go to WAIT next cycle. When core_ready=0, hold ISSUE indefinitely.
- WAIT state:
  - in_ready=0; no start pulses.
  - On core_done:
    - block_cnt increments (saturating).
    - If last_blk: digest_out<=core_digest, digest_valid<=1, first_blk<=1.
    - Otherwise first_blk<=0.
    - Go to FILL.
- Latency:
  - Beat 3 accepted at cycle T: start pulse at T+1 if core_ready.
  - core_done at cycle D: digest_valid=1 and in_ready=1 at D+1.
  - Best-case host throughput is one block per (4 + core latency + 2) cycles.
- Boundary conditions:
  - core_done outside WAIT is ignored.
  - in_valid while in_ready=0 is ignored; no beat is lost, because the host must hold it.
  - digest_valid stays 1 until the first beat of the next message is accepted.
  - err clears only on reset.
  - Reset mid-operation aborts the message; the core is reset by the same reset.

Decomposition:
- sha256_pkg holds:
  - state enum {FILL, ISSUE, WAIT}.
  - BEATS_PER_BLOCK=4, BEAT_W=128, BLOCK_W=512, DIGEST_W=256.
- A sub-module is not needed. The FSM, beat shifter and counters live in one module. sha256_ctrl is instantiated in place of the bare buffer in the sha256 top, in front of sha_core.

Test Plan:
- Single block "abc" (beats 61626380_00000000_00000000_00000000, 3x zeros with last beat ..._00000018, in_last on beat 3):
  - Exactly one core_init and zero core_next.
  - digest_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, block_cnt=1.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded:
  - core_init, then core_next.
  - digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, block_cnt=2.
- Core back-pressure: hold core_ready=0 for 10 cycles in ISSUE.
  - No start pulse, in_ready=0, core_block stable.
  - Start pulse in the first cycle core_ready=1.
- in_last on beat 1:
  - err=1, no start pulse, beat_cnt back to 0.
  - The following valid "abc" message still produces the correct digest.
- Reset asserted during WAIT:
  - All outputs return to reset values asynchronously.
  - A later "abc" message starts with core_init and yields the correct digest.
- Gapped in_valid (one beat every 3 cycles) plus back-to-back messages:
  - Buffer contents correct.
  - digest_valid drops when the first beat of message 2 is accepted.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and sizes for the SHA-256 block sequencer.
// The host streams 128-bit beats that are gathered into 512-bit compression blocks.
package sha256_pkg;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT
  } state_t;

  localparam int BEATS_PER_BLOCK = 4;
  localparam int BEAT_W          = 128;
  localparam int BLOCK_W         = 512;
  localparam int DIGEST_W        = 256;

endpackage

// File: rtl/sha256_ctrl.sv
// Gathers four host beats into a 512-bit block, starts the compression core
// with init or next, and publishes the digest after the message's last block.
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BEAT_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [BLOCK_W-1:0]  core_block,
  output logic                core_init,
  output logic                core_next,
  input  logic                core_ready,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic [DIGEST_W-1:0] digest_out,
  output logic                digest_valid,
  output logic [CNT_W-1:0]    block_cnt,
  output logic                err
);

  localparam int BEAT_CNT_W = $clog2(BEATS_PER_BLOCK);

  state_t                state;
  state_t                state_next;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  first_blk;
  logic                  last_blk;
  logic [BLOCK_W-1:0]    buffer;
  logic                  accept;
  logic                  block_full;

  assign accept     = in_valid && in_ready;
  assign block_full = (beat_cnt == BEAT_CNT_W'(BEATS_PER_BLOCK - 1));
  assign core_block = buffer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    core_init  = 1'b0;
    core_next  = 1'b0;
    case (state)
      FILL: begin
        in_ready = !reset;
        if (accept && block_full) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_init = core_ready && first_blk;
        core_next = core_ready && !first_blk;
        if (core_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (core_done) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt     <= '0;
      first_blk    <= 1'b1;
      last_blk     <= 1'b0;
      buffer       <= '0;
      digest_out   <= '0;
      digest_valid <= 1'b0;
      block_cnt    <= '0;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        // Earliest beat ends up in the top 128 bits once four have arrived.
        buffer   <= {buffer[BLOCK_W-BEAT_W-1:0], in_data};
        beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
        if (first_blk && beat_cnt == '0) begin
          digest_valid <= 1'b0;
          block_cnt    <= '0;
        end
        if (block_full) begin
          last_blk <= in_last;
        end else if (in_last) begin
          // A message ending mid-block is malformed: drop the partial block.
          err       <= 1'b1;
          beat_cnt  <= '0;
          first_blk <= 1'b1;
        end
      end
      if (state == WAIT && core_done) begin
        if (block_cnt != '1) begin
          block_cnt <= block_cnt + CNT_W'(1);
        end
        if (last_blk) begin
          digest_out   <= core_digest;
          digest_valid <= 1'b1;
          first_blk    <= 1'b1;
        end else begin
          first_blk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed bench for sha256_ctrl; a behavioural SHA-256 core answers the start
// pulses so that the published digests can be compared to known test vectors.
module tb_sha256_ctrl;
  import sha256_pkg::*;

  localparam int CNT_W = 16;
  localparam int LAT   = 6;

  logic                clk;
  logic                reset;
  logic [BEAT_W-1:0]   in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [BLOCK_W-1:0]  core_block;
  logic                core_init;
  logic                core_next;
  logic                core_ready;
  logic                core_done;
  logic [DIGEST_W-1:0] core_digest;
  logic [DIGEST_W-1:0] digest_out;
  logic                digest_valid;
  logic [CNT_W-1:0]    block_cnt;
  logic                err;

  sha256_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .core_block(core_block),
    .core_init(core_init), .core_next(core_next), .core_ready(core_ready),
    .core_done(core_done), .core_digest(core_digest), .digest_out(digest_out),
    .digest_valid(digest_valid), .block_cnt(block_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [511:0] ABC_BLK = {
    128'h61626380_00000000_00000000_00000000, 128'h0, 128'h0,
    128'h00000000_00000000_00000000_00000018};
  localparam logic [511:0] TWO_BLK1 = {
    128'h61626364_62636465_63646566_64656667, 128'h65666768_66676869_6768696a_68696a6b,
    128'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f, 128'h6d6e6f70_6e6f7071_80000000_00000000};
  localparam logic [511:0] TWO_BLK2 = {
    128'h0, 128'h0, 128'h0, 128'h00000000_00000000_00000000_000001c0};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural core: takes a start pulse when ready, answers LAT+1 cycles later.
  logic           busy;
  logic           hold;
  int unsigned    lat_cnt;
  logic [255:0]   hv;
  int             init_cnt = 0;
  int             next_cnt = 0;

  assign core_ready  = !busy && !hold;
  assign core_digest = hv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      core_done <= 1'b0;
      hv        <= '0;
      lat_cnt   <= 0;
    end else begin
      core_done <= 1'b0;
      if (core_init) init_cnt <= init_cnt + 1;
      if (core_next) next_cnt <= next_cnt + 1;
      if (busy) begin
        if (lat_cnt == 0) begin
          busy      <= 1'b0;
          core_done <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end else if (core_ready && (core_init || core_next)) begin
        busy    <= 1'b1;
        lat_cnt <= LAT;
        hv      <= compress(core_init ? IV : hv, core_block);
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int base_i;
  int base_n;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [127:0] d, input logic last, input int gap);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
    chk1("beat_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("beat data=%h last=%0b", d, last);
  endtask

  task automatic send_block(input logic [511:0] blk, input logic last, input int gap,
                            input logic first_of_msg, input logic check_start);
    for (int i = 0; i < 4; i++) begin
      send_beat(blk[511-128*i -: 128], last && (i == 3), gap);
      if (i == 0 && first_of_msg) begin
        chk1("first_beat_dvalid", digest_valid, 1'b0);
        chk("first_beat_bcnt", 512'(block_cnt), 512'(0));
      end
    end
    chk("block_buf", core_block, blk);
    if (check_start) begin
      chk1("start_init", core_init, first_of_msg);
      chk1("start_next", core_next, !first_of_msg);
    end
  endtask

  task automatic wait_digest(input logic [255:0] exp, input int exp_blocks);
    for (int n = 0; n < 200 && !digest_valid; n++) @(negedge clk);
    chk1("digest_valid", digest_valid, 1'b1);
    chk1("ready_after_done", in_ready, 1'b1);
    chk("digest", 512'(digest_out), 512'(exp));
    chk("block_cnt", 512'(block_cnt), 512'(exp_blocks));
    $display("digest=%h blocks=%0d", digest_out, block_cnt);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_dvalid", digest_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_init", core_init, 1'b0);
    chk("rst_digest", 512'(digest_out), 512'(0));
    chk("rst_bcnt", 512'(block_cnt), 512'(0));
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);

    // single-block "abc"
    base_i = init_cnt; base_n = next_cnt;
    send_block(ABC_BLK, 1'b1, 0, 1'b1, 1'b1);
    wait_digest(ABC_DIG, 1);
    chk("abc_inits", 512'(init_cnt - base_i), 512'(1));
    chk("abc_nexts", 512'(next_cnt - base_n), 512'(0));

    // two-block message
    base_i = init_cnt; base_n = next_cnt;
    send_block(TWO_BLK1, 1'b0, 0, 1'b1, 1'b1);
    send_block(TWO_BLK2, 1'b1, 0, 1'b0, 1'b1);
    wait_digest(TWO_DIG, 2);
    chk("two_inits", 512'(init_cnt - base_i), 512'(1));
    chk("two_nexts", 512'(next_cnt - base_n), 512'(1));

    // core back-pressure for 10 cycles in ISSUE
    hold = 1'b1;
    base_i = init_cnt;
    send_block(ABC_BLK, 1'b1, 0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk1("bp_init", core_init, 1'b0);
      chk1("bp_next", core_next, 1'b0);
      chk1("bp_ready", in_ready, 1'b0);
      chk("bp_block", core_block, ABC_BLK);
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    chk1("bp_release_init", core_init, 1'b1);
    wait_digest(ABC_DIG, 1);
    chk("bp_inits", 512'(init_cnt - base_i), 512'(1));

    // in_last on beat 1 is a protocol error; a clean message follows
    base_i = init_cnt; base_n = next_cnt;
    send_beat(ABC_BLK[511:384], 1'b0, 0);
    send_beat(128'h0, 1'b1, 0);
    chk1("err_set", err, 1'b1);
    chk1("err_stay_fill", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_no_start", 512'((init_cnt - base_i) + (next_cnt - base_n)), 512'(0));
    send_block(ABC_BLK, 1'b1, 0, 1'b1, 1'b1);
    wait_digest(ABC_DIG, 1);
    chk1("err_sticky", err, 1'b1);

    // reset while waiting on the second block of a message
    send_block(TWO_BLK1, 1'b0, 0, 1'b1, 1'b1);
    send_block(TWO_BLK2, 1'b1, 0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_dvalid", digest_valid, 1'b0);
    chk1("mid_rst_init", core_init, 1'b0);
    chk1("mid_rst_next", core_next, 1'b0);
    chk("mid_rst_bcnt", 512'(block_cnt), 512'(0));
    chk("mid_rst_digest", 512'(digest_out), 512'(0));
    chk("mid_rst_buf", core_block, 512'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    base_i = init_cnt; base_n = next_cnt;
    send_block(ABC_BLK, 1'b1, 0, 1'b1, 1'b1);
    wait_digest(ABC_DIG, 1);
    chk("post_rst_inits", 512'(init_cnt - base_i), 512'(1));
    chk("post_rst_nexts", 512'(next_cnt - base_n), 512'(0));

    // gapped beats (one every 3 cycles), back-to-back messages
    send_block(ABC_BLK, 1'b1, 2, 1'b1, 1'b1);
    wait_digest(ABC_DIG, 1);
    send_block(TWO_BLK1, 1'b0, 2, 1'b1, 1'b1);
    send_block(TWO_BLK2, 1'b1, 2, 1'b0, 1'b1);
    wait_digest(TWO_DIG, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
